sensor_debounce: RTL

Input conditioner placed directly upstream of the sensor state machine: it takes the raw, asynchronous sensor line, synchronizes it into the CLK domain, rejects pulses shorter than a programmable qualification window, and drives the clean level into the sensor FSM's `x` input. It also produces single-cycle edge pulses and a saturating glitch count for diagnostics.

---
 rtl/sensor_pkg.sv | 24 ++
 rtl/sensor_debounce_if.sv | 30 +++
 rtl/sensor_sync.sv | 39 +++
 rtl/sensor_debounce.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/sensor_pkg.sv
// -----------------------------------------------------------------------------
// sensor_pkg
// Shared definitions for the sensor input path: the debounce state encoding
// and the default synchronizer and debounce depths used by sensor_debounce.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package sensor_pkg;

  localparam int SENSOR_SYNC_STAGES = 2;
  localparam int SENSOR_DB_CYCLES   = 8;

  // LOW/HIGH are settled levels; *_PEND are qualifying a change of level.
  typedef enum logic [1:0] {
    LOW       = 2'b00,
    RISE_PEND = 2'b01,
    HIGH      = 2'b10,
    FALL_PEND = 2'b11
  } db_state_t;

  function automatic logic is_pending(input db_state_t s);
    return (s == RISE_PEND) || (s == FALL_PEND);
  endfunction

endpackage

// File: rtl/sensor_debounce_if.sv
// -----------------------------------------------------------------------------
// sensor_debounce_if
// Bundles the raw sensor line, the sample tick and the conditioned outputs.
//   master : drives raw_in / en, observes the conditioned outputs
//   slave  : the debouncer itself
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
interface sensor_debounce_if #(
  parameter int GLITCH_W = 8
);

  logic                raw_in;
  logic                en;
  logic                x_out;
  logic                rise_p;
  logic                fall_p;
  logic                busy;
  logic [GLITCH_W-1:0] glitch_cnt;

  modport master (
    output raw_in, en,
    input  x_out, rise_p, fall_p, busy, glitch_cnt
  );

  modport slave (
    input  raw_in, en,
    output x_out, rise_p, fall_p, busy, glitch_cnt
  );

endinterface

// File: rtl/sensor_sync.sv
// -----------------------------------------------------------------------------
// sensor_sync
// N-flop synchronizer for an asynchronous single-bit input.
//   clk_i   : destination clock
//   rst_ni  : synchronous active-low reset, clears the chain to 0
//   async_i : asynchronous input
//   sync_o  : synchronized output (last stage of the chain)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module sensor_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic sync_o
);

  if (STAGES < 2) begin : g_bad_stages
    $error("sensor_sync: STAGES must be >= 2");
  end

  logic [STAGES-1:0] chain_q;

  // NOTE: every flop in the chain is reset, not just the output stage, so a
  // stale level cannot ripple out of the chain after reset is released.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      chain_q <= '0;
    end else begin
      // NOTE: non-blocking assignment is what makes each stage take the
      // previous stage's old value, i.e. a real shift register.
      chain_q <= {chain_q[STAGES-2:0], async_i};
    end
  end

  assign sync_o = chain_q[STAGES-1];

endmodule

// File: rtl/sensor_debounce.sv
// -----------------------------------------------------------------------------
// sensor_debounce
// Conditions the raw sensor line for the sensor FSM: synchronizes it, accepts
// a level change only after DB_CYCLES consecutive en-qualified samples of the
// new level, emits one-cycle edge pulses and counts rejected changes.
//   CLK : clock, rising edge
//   MR  : synchronous active-low reset
//   bus : sensor_debounce_if.slave
//         raw_in, en                 -> inputs
//         x_out, rise_p, fall_p,
//         busy, glitch_cnt           -> outputs (all from registers)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module sensor_debounce
  import sensor_pkg::*;
#(
  parameter int SYNC_STAGES = SENSOR_SYNC_STAGES,
  parameter int DB_CYCLES   = SENSOR_DB_CYCLES,
  parameter int CNT_W       = $clog2(DB_CYCLES),
  parameter int GLITCH_W    = 8
) (
  input  logic             CLK,
  input  logic             MR,
  sensor_debounce_if.slave bus
);

  if (DB_CYCLES < 2) begin : g_bad_db
    $error("sensor_debounce: DB_CYCLES must be >= 2");
  end

  // Count value on which the next agreeing sample commits the change.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic                sync_q;
  db_state_t           state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [GLITCH_W-1:0] glitch_q, glitch_d;
  logic                glitch_inc;
  logic                rise_q, rise_d;
  logic                fall_q, fall_d;

  sensor_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_i   (CLK),
    .rst_ni  (MR),
    .async_i (bus.raw_in),
    .sync_o  (sync_q)
  );

  // State register, counters and pulse registers.
  always_ff @(posedge CLK) begin
    if (!MR) begin
      state_q  <= LOW;
      cnt_q    <= '0;
      glitch_q <= '0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      glitch_q <= glitch_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  // Next-state logic. Without en everything holds and no pulse is produced.
  always_comb begin
    // NOTE: defaults first so every path assigns every signal; this is what
    // keeps the block combinational instead of inferring latches.
    state_d    = state_q;
    cnt_d      = cnt_q;
    glitch_inc = 1'b0;
    rise_d     = 1'b0;
    fall_d     = 1'b0;

    if (bus.en) begin
      unique case (state_q)
        LOW: begin
          if (sync_q) begin
            state_d = RISE_PEND;
            cnt_d   = CNT_ONE;
          end
        end
        RISE_PEND: begin
          if (!sync_q) begin
            state_d    = LOW;
            cnt_d      = '0;
            glitch_inc = 1'b1;
          end else if (cnt_q == CNT_LAST) begin
            state_d = HIGH;
            cnt_d   = '0;
            rise_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        HIGH: begin
          if (!sync_q) begin
            state_d = FALL_PEND;
            cnt_d   = CNT_ONE;
          end
        end
        FALL_PEND: begin
          if (sync_q) begin
            state_d    = HIGH;
            cnt_d      = '0;
            glitch_inc = 1'b1;
          end else if (cnt_q == CNT_LAST) begin
            state_d = LOW;
            cnt_d   = '0;
            fall_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = LOW;
          cnt_d   = '0;
        end
      endcase
    end

    // Saturating: once all-ones the count sticks.
    glitch_d = (glitch_inc && (glitch_q != '1)) ? glitch_q + 1'b1 : glitch_q;
  end

  // Outputs decode straight from registers, so no input reaches an output
  // combinationally. x_out stays at the old level while a change is pending.
  always_comb begin
    bus.x_out      = (state_q == HIGH) || (state_q == FALL_PEND);
    bus.busy       = is_pending(state_q);
    bus.rise_p     = rise_q;
    bus.fall_p     = fall_q;
    bus.glitch_cnt = glitch_q;
  end

endmodule
